// File: rtl/pulse_cmd_fifo.sv
// Command buffer between the processor core's pulse strobe and the downstream element interface.
// First-word-fall-through FIFO with a registered head word and sticky overflow accounting.
module pulse_cmd_fifo #(
   parameter int CMD_WIDTH      = 72,
   parameter int DEPTH          = 8,
   parameter int DROP_CNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CMD_WIDTH-1:0]      cmd_in,
   input  logic                      cstrobe_in,
   output logic [CMD_WIDTH-1:0]      cmd_data,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      full,
   output logic                      overflow,
   output logic [DROP_CNT_WIDTH-1:0] drop_count,
   input  logic                      clr_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = DROP_CNT_WIDTH;

   logic [CMD_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]        r_rdPtr;
   logic [AW-1:0]        r_wrPtr;
   logic [LW-1:0]        r_level;
   logic [CMD_WIDTH-1:0] r_cmdData;
   logic                 r_overflow;
   logic [DW-1:0]        r_dropCount;

   logic                 w_full;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   logic [AW-1:0]        w_nextRd;
   logic [LW-1:0]        w_levelNext;

   assign w_full   = (r_level == LW'(DEPTH));
   assign w_pop    = (r_level != '0) && cmd_ready;
   assign w_push   = cstrobe_in && (!w_full || w_pop);
   assign w_drop   = cstrobe_in && w_full && !w_pop;
   assign w_nextRd = w_pop ? r_rdPtr + AW'(1) : r_rdPtr;

   always_comb begin
      w_levelNext = r_level;
      case ({w_push, w_pop})
         2'b10:   w_levelNext = r_level + LW'(1);
         2'b01:   w_levelNext = r_level - LW'(1);
         default: w_levelNext = r_level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset && w_push) begin
         r_mem[r_wrPtr] <= cmd_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_level <= '0;
      end else begin
         r_rdPtr <= w_nextRd;
         if (w_push) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         r_level <= w_levelNext;
      end
   end

   // Head register: when the new head is the slot being written this edge, take cmd_in directly.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cmdData <= '0;
      end else if (w_push && (w_nextRd == r_wrPtr)) begin
         r_cmdData <= cmd_in;
      end else if (w_levelNext != '0) begin
         r_cmdData <= r_mem[w_nextRd];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_overflow  <= 1'b0;
         r_dropCount <= '0;
      end else if (w_drop) begin
         r_overflow  <= 1'b1;
         if (clr_overflow) begin
            r_dropCount <= DW'(1);
         end else if (r_dropCount != '1) begin
            r_dropCount <= r_dropCount + DW'(1);
         end
      end else if (clr_overflow) begin
         r_overflow  <= 1'b0;
         r_dropCount <= '0;
      end
   end

   assign cmd_data   = r_cmdData;
   assign cmd_valid  = (r_level != '0);
   assign level      = r_level;
   assign full       = w_full;
   assign overflow   = r_overflow;
   assign drop_count = r_dropCount;

endmodule

// File: tb/tb_pulse_cmd_fifo.sv
// Self-checking bench for pulse_cmd_fifo: directed scenarios plus random traffic,
// all compared every cycle against a queue-based model of the command buffer.
module tb_pulse_cmd_fifo;

   logic        clk;
   logic        reset;
   logic [71:0] cmd_in;
   logic        cstrobe_in;
   logic [71:0] cmd_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  level;
   logic        full;
   logic        overflow;
   logic [7:0]  drop_count;
   logic        clr_overflow;

   int totalChecks = 0;
   int badChecks   = 0;

   logic [71:0] modelQ[$];
   logic [71:0] poppedQ[$];
   int          modelDrops = 0;
   bit          modelOvf   = 0;
   bit          modelLive  = 0;

   pulse_cmd_fifo #(.CMD_WIDTH(72), .DEPTH(8), .DROP_CNT_WIDTH(8)) dut (
      .clk(clk),
      .reset(reset),
      .cmd_in(cmd_in),
      .cstrobe_in(cstrobe_in),
      .cmd_data(cmd_data),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .level(level),
      .full(full),
      .overflow(overflow),
      .drop_count(drop_count),
      .clr_overflow(clr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
      totalChecks++;
      if (act !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue updated from the handshake rules at each rising edge.
   always @(posedge clk) begin
      bit doPop, doPush, doDrop, isFull;
      if (!reset) begin
         modelQ.delete();
         modelOvf   = 0;
         modelDrops = 0;
         modelLive  = 1;
      end else if (modelLive) begin
         isFull = (modelQ.size() == 8);
         doPop  = (modelQ.size() != 0) && cmd_ready;
         doPush = cstrobe_in && (!isFull || doPop);
         doDrop = cstrobe_in && isFull && !doPop;
         if (doPop) poppedQ.push_back(modelQ.pop_front());
         if (doPush) modelQ.push_back(cmd_in);
         if (doDrop) begin
            modelOvf   = 1;
            modelDrops = clr_overflow ? 1 : ((modelDrops == 255) ? 255 : modelDrops + 1);
         end else if (clr_overflow) begin
            modelOvf   = 0;
            modelDrops = 0;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model, away from the active edge.
   always @(negedge clk) begin
      if (modelLive) begin
         checkOutput("level", 72'(level), 72'(modelQ.size()));
         checkOutput("valid", 72'(cmd_valid), 72'(modelQ.size() != 0));
         checkOutput("full", 72'(full), 72'(modelQ.size() == 8));
         checkOutput("overflow", 72'(overflow), 72'(modelOvf));
         checkOutput("dropCount", 72'(drop_count), 72'(modelDrops));
         if (modelQ.size() != 0) checkOutput("data", cmd_data, modelQ[0]);
      end
   end

   task automatic applyStimulus(input bit strobe, input logic [71:0] data, input bit ready,
                                input bit clr, input bit rstN);
      cstrobe_in   = strobe;
      cmd_in       = data;
      cmd_ready    = ready;
      clr_overflow = clr;
      reset        = rstN;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int readyPct;
      cstrobe_in   = 0;
      cmd_in       = '0;
      cmd_ready    = 0;
      clr_overflow = 0;
      reset        = 0;
      @(negedge clk);

      // Reset held with strobe asserted
      applyStimulus(1, 72'h5, 0, 0, 0);
      applyStimulus(1, 72'h6, 0, 0, 0);
      checkOutput("rstLevel", 72'(level), 72'd0);
      checkOutput("rstValid", 72'(cmd_valid), 72'd0);
      checkOutput("rstOverflow", 72'(overflow), 72'd0);

      // Basic push with downstream stalled
      applyStimulus(1, 72'h11_2233_4455_6677_8899, 0, 0, 1);
      checkOutput("basicValid", 72'(cmd_valid), 72'd1);
      checkOutput("basicData", cmd_data, 72'h11_2233_4455_6677_8899);
      checkOutput("basicLevel", 72'(level), 72'd1);
      applyStimulus(0, 72'h0, 1, 0, 1);
      checkOutput("basicDrained", 72'(level), 72'd0);

      // Order and pointer wrap with ready always high
      poppedQ.delete();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 72'(i), 1, 0, 1);
         checkOutput("streamData", cmd_data, 72'(i));
         checkOutput("streamLevel", 72'(level), 72'd1);
      end
      applyStimulus(0, 72'h0, 1, 0, 1);
      checkOutput("streamCount", 72'(poppedQ.size()), 72'd20);
      if (poppedQ.size() == 20)
         for (int i = 0; i < 20; i++) checkOutput("streamOrder", poppedQ[i], 72'(i));

      // Fill past capacity, then drain
      for (int i = 0; i < 10; i++) applyStimulus(1, 72'(i), 0, 0, 1);
      checkOutput("fillFull", 72'(full), 72'd1);
      checkOutput("fillOverflow", 72'(overflow), 72'd1);
      checkOutput("fillDrops", 72'(drop_count), 72'd2);
      poppedQ.delete();
      for (int i = 0; i < 8; i++) applyStimulus(0, 72'h0, 1, 0, 1);
      checkOutput("drainCount", 72'(poppedQ.size()), 72'd8);
      if (poppedQ.size() == 8)
         for (int i = 0; i < 8; i++) checkOutput("drainOrder", poppedQ[i], 72'(i));
      checkOutput("drainLevel", 72'(level), 72'd0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 8; i++) applyStimulus(1, 72'h200 + 72'(i), 0, 0, 1);
      poppedQ.delete();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 72'h300 + 72'(i), 1, 0, 1);
         checkOutput("ppLevel", 72'(level), 72'd8);
         checkOutput("ppDrops", 72'(drop_count), 72'd2);
      end
      for (int i = 0; i < 8; i++) applyStimulus(0, 72'h0, 1, 0, 1);
      checkOutput("ppCount", 72'(poppedQ.size()), 72'd11);
      if (poppedQ.size() == 11) begin
         for (int i = 0; i < 8; i++) checkOutput("ppOld", poppedQ[i], 72'h200 + 72'(i));
         for (int i = 0; i < 3; i++) checkOutput("ppNew", poppedQ[8 + i], 72'h300 + 72'(i));
      end

      // Clear versus drop, then saturation
      applyStimulus(0, 72'h0, 0, 1, 1);
      checkOutput("clrDrops0", 72'(drop_count), 72'd0);
      for (int i = 0; i < 8; i++) applyStimulus(1, 72'h400 + 72'(i), 0, 0, 1);
      for (int i = 0; i < 5; i++) applyStimulus(1, 72'hDEAD, 0, 0, 1);
      checkOutput("fiveDrops", 72'(drop_count), 72'd5);
      applyStimulus(1, 72'hDEAD, 0, 1, 1);
      checkOutput("clrDropOvf", 72'(overflow), 72'd1);
      checkOutput("clrDropCnt", 72'(drop_count), 72'd1);
      applyStimulus(0, 72'h0, 0, 1, 1);
      checkOutput("clrOnlyOvf", 72'(overflow), 72'd0);
      checkOutput("clrOnlyCnt", 72'(drop_count), 72'd0);
      for (int i = 0; i < 300; i++) applyStimulus(1, 72'hBEEF, 0, 0, 1);
      checkOutput("satCount", 72'(drop_count), 72'd255);

      // Reset mid-stream
      for (int i = 0; i < 3; i++) applyStimulus(0, 72'h0, 1, 0, 1);
      checkOutput("midLevel5", 72'(level), 72'd5);
      applyStimulus(1, 72'h501, 0, 0, 1);
      applyStimulus(0, 72'h0, 1, 0, 1);
      applyStimulus(1, 72'h502, 1, 0, 0);
      checkOutput("midRstLevel", 72'(level), 72'd0);
      checkOutput("midRstValid", 72'(cmd_valid), 72'd0);
      checkOutput("midRstDrops", 72'(drop_count), 72'd0);
      applyStimulus(1, 72'hAB, 0, 0, 1);
      checkOutput("abData", cmd_data, 72'hAB);
      poppedQ.delete();
      applyStimulus(0, 72'h0, 1, 0, 1);
      checkOutput("abFirstCount", 72'(poppedQ.size()), 72'd1);
      if (poppedQ.size() != 0) checkOutput("abFirst", poppedQ[0], 72'hAB);

      // Random traffic with shifting back-pressure
      readyPct = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) readyPct = $urandom_range(5, 95);
         applyStimulus($urandom_range(0, 99) < 60,
                       {$urandom, $urandom, $urandom},
                       $urandom_range(0, 99) < readyPct,
                       $urandom_range(0, 99) < 3,
                       $urandom_range(0, 299) != 0);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/pulse_cmd_fifo.md
Name: pulse_cmd_fifo

Overview:
- Downstream stage of the processor core. Captures each 72-bit pulse command the core emits on its command strobe.
- Buffers commands in a small synchronous FIFO and presents them to the signal-generator/element interface via a valid/ready handshake.
- Decouples the core's single-cycle strobes from downstream back-pressure. Reports overflow (dropped commands) and fill level for debug.

Parameters:
- CMD_WIDTH, 72: width of a pulse command word; matches the core's pulse output.
- DEPTH, 8: number of FIFO entries; must be a power of two, at least 2.
- DROP_CNT_WIDTH, 8: width of the saturating dropped-command counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- cmd_in  input  CMD_WIDTH  pulse command word from the processor core.
- cstrobe_in  input  1  push strobe from the processor core; one command per high cycle.
- cmd_data  output  CMD_WIDTH  head-of-queue command.
- cmd_valid  output  1  head entry present.
- cmd_ready  input  1  downstream accepts the head entry.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky; set when a strobe was dropped.
- drop_count  output  DROP_CNT_WIDTH  saturating count of dropped strobes.
- clr_overflow  input  1  clears overflow and drop_count.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Read and write pointers, level, overflow and drop_count go to 0. cmd_valid=0, full=0, cmd_data=0.
  - Memory contents are don't-care.
  - Reset overrides every other input that cycle.
  - Reset mid-operation discards all queued entries; no partial output.
- Pop: occurs when cmd_valid && cmd_ready at a clk edge. rd_ptr advances mod DEPTH.
- Push: occurs when cstrobe_in && (!full || pop). cmd_in is written at wr_ptr; wr_ptr advances mod DEPTH.
- First-word-fall-through:
  - cmd_valid = (level != 0). cmd_data shows mem[rd_ptr] whenever cmd_valid=1; it is registered/valid from memory with no extra pop latency.
  - A push into an empty FIFO makes cmd_valid=1 on the cycle after the push edge (latency 1). It is never combinationally visible in the push cycle.
- cmd_data when cmd_valid=0 holds its last value; verification does not check it.
- Level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous push and pop: both happen, level stays DEPTH, and no drop.
- Empty with push: the push is accepted. No pop is possible since cmd_valid=0.
- Drop: cstrobe_in && full && !pop.
  - The word is discarded and the queue is unchanged.
  - overflow is set from the next cycle.
  - drop_count increments, saturating at 2^DROP_CNT_WIDTH-1.
- clr_overflow=1: overflow and drop_count go to 0 next cycle. If a drop occurs in the same cycle, the set wins: overflow=1 and drop_count=1.
- Pointers wrap mod DEPTH. full/empty are derived from level, not from pointer equality.
- cmd_ready may be high while cmd_valid=0; it has no effect.
- The handshake contract applies downstream: while cmd_valid=1 && cmd_ready=0, cmd_data holds stable.
- No combinational path from cmd_ready to cmd_valid or cmd_data. All outputs are registered or decoded from registers.

Test Plan:
- Reset and basic push:
  - Hold reset=0 for 2 cycles with cstrobe_in=1: level=0, cmd_valid=0, overflow=0 throughout.
  - Then release reset, push 0x11_2233_4455_6677_8899 once with cmd_ready=0: the next cycle cmd_valid=1, cmd_data matches, level=1.
- Order and wrap:
  - Push 20 sequential words (cmd_in=i) with cmd_ready=1 every cycle.
  - Output must be the same 0..19 in order, with each word appearing 1 cycle after its push.
  - level never exceeds 1; pointers wrap at 8 with no loss.
- Fill and overflow:
  - With cmd_ready=0, push 10 words: full=1 after 8; words 8 and 9 are dropped; overflow=1, drop_count=2.
  - Then drain: exactly words 0..7 emerge.
- Full with simultaneous push and pop:
  - At level=8, assert cstrobe_in and cmd_ready together for 3 cycles.
  - level stays 8, drop_count unchanged, and the 3 new words appear after the original 8.
- Clear versus drop:
  - At full with drop_count=5, assert clr_overflow together with a dropping strobe: next cycle overflow=1, drop_count=1.
  - clr_overflow alone: next cycle overflow=0, drop_count=0.
  - 300 drops: drop_count saturates at 255.
- Reset mid-stream:
  - With level=5 and cmd_ready toggling, pull reset=0 for 1 cycle.
  - Next cycle level=0, cmd_valid=0; a subsequent push of 0xAB emerges as the first word.
